// File: rtl/param_shift_register.sv
// Lane-oriented shift register with shift-in/shift-out/parallel-load, fill count and sticky flags.
// Optional rotate-on-shift-out build selected by macro PARAM_SHIFT_REGISTER_ROTATE_EN.
module param_shift_register #(
  parameter int LANE_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [LANE_W-1:0]          in_data,
  input  logic [LANE_W*DEPTH-1:0]    par_in,
  output logic [LANE_W-1:0]          out_data,
  output logic [LANE_W*DEPTH-1:0]    par_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       udf
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    MODE_HOLD      = 2'b00,
    MODE_SHIFT_IN  = 2'b01,
    MODE_SHIFT_OUT = 2'b10,
    MODE_LOAD      = 2'b11
  } mode_e;

  // Lane k lives at bits [k*LANE_W +: LANE_W], so the packed array maps directly onto par_out.
  logic [DEPTH-1:0][LANE_W-1:0] lanes_q, lanes_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         ovf_q, ovf_d;
  logic                         udf_q, udf_d;

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    lanes_d = lanes_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;

    if (en) begin
      case (mode_e'(mode))
        MODE_SHIFT_IN: begin
          for (int k = 0; k < DEPTH - 1; k++) begin
            lanes_d[k] = lanes_q[k+1];
          end
          lanes_d[DEPTH-1] = in_data;
          if (count_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end

        MODE_SHIFT_OUT: begin
          for (int k = 1; k < DEPTH; k++) begin
            lanes_d[k] = lanes_q[k-1];
          end
`ifdef PARAM_SHIFT_REGISTER_ROTATE_EN
          // Rotation keeps every lane, so occupancy and udf are untouched.
          lanes_d[0] = lanes_q[DEPTH-1];
`else
          // An empty register still shifts; only the count saturates.
          lanes_d[0] = '0;
          if (count_q == '0) begin
            udf_d = 1'b1;
          end else begin
            count_d = count_q - CNT_ONE;
          end
`endif
        end

        MODE_LOAD: begin
          lanes_d = par_in;
          count_d = CNT_MAX;
          ovf_d   = 1'b0;
          udf_d   = 1'b0;
        end

        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  // The lanes are plain flops (not a RAM), so they are reset along with the control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      lanes_q <= lanes_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign par_out  = lanes_q;
  assign out_data = lanes_q[DEPTH-1];
  assign count    = count_q;
  assign full     = (count_q == CNT_MAX);
  assign empty    = (count_q == '0);
  assign ovf      = ovf_q;
  assign udf      = udf_q;

endmodule
